// File: rtl/addr_hash_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_hash_pipe: 3-stage fold / multiply-add-shift address-to-bucket hasher
// Rev 1.0
// ----------------------------------------------------------------------------
module addr_hash_pipe #(
  parameter int ADDR_WIDTH     = 64,
  parameter int MAX_LG_BUCKETS = 16,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAX_LG_BUCKETS-1:0]   out_bucket,
  output logic [TAG_WIDTH-1:0]        out_tag,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [31:0]                 cfg_num_buckets,
  input  logic [ADDR_WIDTH/2-1:0]     cfg_coe_a,
  input  logic [ADDR_WIDTH/2-1:0]     cfg_coe_b,
  output logic                        cfg_err
);

  localparam int W   = ADDR_WIDTH / 2;
  localparam int LGW = $clog2(W + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t                    state;
  logic [LGW-1:0]            lg;
  logic [W-1:0]              coe_a;
  logic [W-1:0]              coe_b;

  logic                      s1_valid;
  logic [W-1:0]              s1_x;
  logic [TAG_WIDTH-1:0]      s1_tag;
  logic                      s2_valid;
  logic [W-1:0]              s2_prod;
  logic [TAG_WIDTH-1:0]      s2_tag;

  logic                      advance;
  logic                      accept;
  logic [W-1:0]              fold;
  logic [W-1:0]              hash;
  logic [LGW-1:0]            shamt;
  logic [MAX_LG_BUCKETS-1:0] bucket;

  logic [31:0]               n_m1;
  logic [5:0]                req_lg;
  logic                      clamp;
  logic [LGW-1:0]            lg_next;

  assign advance  = !out_valid || out_ready;
  // A pending config blocks new requests in the very cycle it is seen.
  assign in_ready = (state == RUN) && advance && !cfg_valid;
  assign accept   = in_valid && in_ready;

  assign fold   = in_addr[ADDR_WIDTH-1:W] ^ in_addr[W-1:0];
  assign hash   = s2_prod + coe_b;
  assign shamt  = LGW'(W) - lg;
  assign bucket = (lg == '0) ? '0 : MAX_LG_BUCKETS'(hash >> shamt);

  // ceil(log2(n)) is the bit length of n-1 for n >= 2.
  assign n_m1 = cfg_num_buckets - 32'd1;
  always_comb begin
    req_lg = '0;
    if (cfg_num_buckets > 32'd1) begin
      for (int i = 0; i < 32; i++) begin
        if (n_m1[i]) req_lg = 6'(i + 1);
      end
    end
  end
  assign clamp   = req_lg > 6'(MAX_LG_BUCKETS);
  assign lg_next = clamp ? LGW'(MAX_LG_BUCKETS) : LGW'(req_lg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      lg        <= '0;
      coe_a     <= W'(1);
      coe_b     <= '0;
    end else begin
      cfg_ready <= 1'b0;
      case (state)
        RUN: begin
          if (cfg_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid && !out_valid) begin
            state     <= APPLY;
            cfg_ready <= 1'b1;
          end
        end
        APPLY: begin
          lg    <= lg_next;
          coe_a <= cfg_coe_a;
          coe_b <= cfg_coe_b;
          if (clamp) cfg_err <= 1'b1;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // All stages move in lockstep; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_prod    <= '0;
      s2_tag     <= '0;
      out_valid  <= 1'b0;
      out_bucket <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (accept) begin
        s1_x   <= fold;
        s1_tag <= in_tag;
      end
      if (s1_valid) begin
        s2_prod <= coe_a * s1_x;
        s2_tag  <= s1_tag;
      end
      if (s2_valid) begin
        out_bucket <= bucket;
        out_tag    <= s2_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_hash_pipe.sv
`default_nettype none
// tb_addr_hash_pipe: randomized scoreboard bench for addr_hash_pipe with an
// arithmetic reference model and a decoupled output monitor.
module tb_addr_hash_pipe;

  localparam int AW = 64;
  localparam int W  = 32;
  localparam int ML = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [ML-1:0] out_bucket;
  logic [TW-1:0] out_tag;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   cfg_num_buckets = '0;
  logic [W-1:0]  cfg_coe_a = '0;
  logic [W-1:0]  cfg_coe_b = '0;
  logic          cfg_err;

  addr_hash_pipe #(.ADDR_WIDTH(AW), .MAX_LG_BUCKETS(ML), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_bucket(out_bucket), .out_tag(out_tag),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_buckets(cfg_num_buckets),
    .cfg_coe_a(cfg_coe_a), .cfg_coe_b(cfg_coe_b), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rmode = 0;
  int          last_hs = 0;
  logic [63:0] m_lg = 0;
  logic [63:0] m_a = 1;
  logic [63:0] m_b = 0;
  logic        m_err = 1'b0;
  logic [ML+TW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int calc_lg(input logic [31:0] n, output bit clamped);
    int l = 0;
    clamped = 1'b0;
    while ((64'd1 << l) < {32'd0, n}) l++;
    if (l > ML) begin
      l = ML;
      clamped = 1'b1;
    end
    return l;
  endfunction

  function automatic logic [ML+TW-1:0] model(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    logic [63:0] x, h, bkt;
    x   = {32'd0, addr[63:32] ^ addr[31:0]};
    h   = (m_a * x + m_b) % (64'd1 << W);
    bkt = (m_lg == 0) ? 64'd0 : (h >> (W - m_lg));
    return {bkt[ML-1:0], tag};
  endfunction

  // out_ready policy: 0 = always high, 1 = random, 2 = held low
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: every presented output must match the oldest expected entry,
  // including every stalled cycle, which also proves the output holds.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("out_bucket", {48'd0, out_bucket}, {48'd0, exp_q[0][ML+TW-1:TW]});
        chk("out_tag", {56'd0, out_tag}, {56'd0, exp_q[0][TW-1:0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          last_hs = cyc + 1;
        end
      end
    end
  end

  // exp_b < 0: expectation from the model; otherwise the given bucket.
  task automatic send(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                      input int exp_b, output int acc);
    int n = 0;
    logic [ML+TW-1:0] e;
    in_valid = 1'b1; in_addr = addr; in_tag = tag; acc = -1;
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e = model(addr, tag);
        if (exp_b >= 0) e[ML+TW-1:TW] = ML'(exp_b);
        exp_q.push_back(e);
        acc = cyc + 1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (acc < 0) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_cfg(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat);
    int k = 0;
    bit seen = 1'b0;
    bit clamped;
    int l;
    cfg_valid = 1'b1; cfg_num_buckets = n; cfg_coe_a = a; cfg_coe_b = b;
    while (!seen && k < 400) begin
      @(negedge clk);
      chk("in_ready_during_cfg", {63'd0, in_ready}, 64'd0);
      if (cfg_ready === 1'b1) begin
        seen = 1'b1;
        chk("drained_before_apply", 64'(exp_q.size()), 64'd0);
        if (exp_lat >= 0) chk("cfg_ready_latency", 64'(k), 64'(exp_lat));
        l = calc_lg(n, clamped);
        m_lg = 64'(l); m_a = {32'd0, a}; m_b = {32'd0, b};
        if (clamped) m_err = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    cfg_valid = 1'b0;
    if (!seen) chk("cfg_ready_timeout", {63'd0, cfg_ready}, 64'd1);
    @(negedge clk);
    chk("cfg_ready_single_pulse", {63'd0, cfg_ready}, 64'd0);
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
    @(posedge clk); #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [AW-1:0] ADDR0 = 64'haaaaaaaabbbbbbbb;

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_bucket", {48'd0, out_bucket}, 64'd0);
    chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // defaults and 3-cycle latency
    send(ADDR0, 8'h5A, 0, acc);
    in_valid = 1'b0;
    wait_empty();
    chk("latency", 64'(last_hs - acc), 64'd3);

    // directed configurations with hand-derived buckets
    do_cfg(32'd16, 32'd1, 32'd0, 2);          send(ADDR0, 8'h01, 1, acc);     in_valid = 1'b0; wait_empty();
    do_cfg(32'd256, 32'd1, 32'd0, 2);         send(ADDR0, 8'h02, 'h11, acc);  in_valid = 1'b0; wait_empty();
    do_cfg(32'd16, 32'd3, 32'd0, 2);          send(ADDR0, 8'h03, 3, acc);     in_valid = 1'b0; wait_empty();
    do_cfg(32'd16, 32'd1, 32'hF0000000, 2);   send(ADDR0, 8'h04, 0, acc);     in_valid = 1'b0; wait_empty();
    do_cfg(32'd20, 32'd1, 32'hF0000000, 2);   send(ADDR0, 8'h05, 0, acc);     in_valid = 1'b0; wait_empty();
    do_cfg(32'h00100000, 32'd1, 32'hF0000000, 2);
    send(ADDR0, 8'h06, 'h0111, acc);          in_valid = 1'b0; wait_empty();

    // back-to-back with random backpressure
    rmode = 1;
    for (int i = 0; i < 10; i++) send({$urandom, $urandom}, 8'(i), -1, acc);
    in_valid = 1'b0;
    wait_empty();

    // reconfigure with three requests in flight
    rmode = 0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 8'(8'h30 + i), -1, acc);
    in_valid = 1'b0;
    do_cfg(32'd1000, $urandom | 32'd1, $urandom, -1);
    send({$urandom, $urandom}, 8'h40, -1, acc);
    in_valid = 1'b0;
    wait_empty();

    // random configurations and traffic
    rmode = 1;
    for (int it = 0; it < 6; it++) begin
      logic [31:0] n;
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(0, 2);
        1:       n = 32'd1 << $urandom_range(1, 20);
        2:       n = $urandom;
        default: n = $urandom_range(3, 70000);
      endcase
      do_cfg(n, $urandom | 32'd1, $urandom, -1);
      for (int i = 0; i < 15; i++) send({$urandom, $urandom}, 8'($urandom), -1, acc);
      in_valid = 1'b0;
    end
    wait_empty();

    // reset in the middle of DRAIN with the output stalled
    do_cfg(32'd4096, 32'd5, 32'd7, -1);
    rmode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 8'(8'h70 + i), -1, acc);
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_num_buckets = 32'd64; cfg_coe_a = 32'd9; cfg_coe_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stuck_drain_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    exp_q.delete();
    m_lg = 0; m_a = 1; m_b = 0; m_err = 1'b0;
    cfg_valid = 1'b0;
    rmode = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    chk("post_rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    @(posedge clk); #1;
    send({$urandom, $urandom}, 8'h99, 0, acc);
    in_valid = 1'b0;
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addr_hash_pipe.md
# addr_hash_pipe

Pipelined, parametrised address-to-bucket hasher: folds an ADDR_WIDTH address, applies multiply-add-shift universal hashing, and returns a bucket index for a runtime-configurable power-of-two bucket count. It sits between the request front end and the bucket tables and replaces per-call functional hashing with a streaming valid/ready datapath. Reconfiguration (bucket count, coefficients) is handshaked and applied only after in-flight requests drain, so every result is computed with one consistent configuration.

## Interface
- ADDR_WIDTH, 64: input address width; must be even; hash word width W = ADDR_WIDTH/2.
- MAX_LG_BUCKETS, 16: maximum log2 bucket count; 1..W.
- TAG_WIDTH, 8: opaque request tag carried alongside each address.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1: request handshake.
- in_addr  in  ADDR_WIDTH: address to hash.
- in_tag  in  TAG_WIDTH: request tag.
- out_valid / out_ready  out / in  1 / 1: result handshake.
- out_bucket  out  MAX_LG_BUCKETS: bucket index, zero-extended.
- out_tag  out  TAG_WIDTH: tag of the request producing out_bucket.
- cfg_valid / cfg_ready  in / out  1 / 1: configuration handshake.
- cfg_num_buckets  in  32: requested bucket count.
- cfg_coe_a, cfg_coe_b  in  W each: multiplier and addend.
- cfg_err  out  1: sticky, set when an accepted cfg_num_buckets was clamped.

## Operation
- Fold: x = addr[ADDR_WIDTH-1:W] ^ addr[W-1:0].
- Hash: h = (coe_a * x + coe_b) mod 2^W (all W-bit, carries discarded); out_bucket = h >> (W - lg); lg = 0 gives out_bucket = 0.
- lg from cfg_num_buckets: 0 or 1 -> 0; otherwise ceil(log2(n)) (non-powers of two round up); if > MAX_LG_BUCKETS, lg = MAX_LG_BUCKETS and cfg_err set (cleared only by reset).
- coe_a is used as given; software keeps it odd.
- Pipeline: S1 register fold+tag; S2 register W-bit product; S3 register add, shift, tag -> outputs.
- Global advance = !out_valid || out_ready; all stages move together; no bubbles squeezed.
- FSM states: RUN, DRAIN, APPLY.
  - RUN: in_ready = advance. cfg_valid high -> DRAIN (in_ready drops the same cycle the FSM leaves RUN; input not accepted in that transition cycle if cfg_valid was high).
  - DRAIN: in_ready = 0; pipeline keeps advancing; when S1..S3 valids all 0 -> APPLY.
  - APPLY: active lg/coe_a/coe_b load from cfg_* inputs; cfg_ready = 1 for this cycle only (cfg transfer completes here); -> RUN.
- cfg_* must be held stable while cfg_valid is high until cfg_ready.
- cfg_ready is 0 in RUN and DRAIN.

## Timing
- Reset (async assert, sync deassert expected upstream): FSM = RUN; all stage valids 0; out_valid 0, out_bucket 0, out_tag 0; cfg_ready 0; cfg_err 0; lg 0, coe_a 1, coe_b 0.
- Latency: request accepted at edge N -> out_valid at edge N+3 when out_ready is held high; throughput 1/cycle.
- out_ready low: out_valid, out_bucket, out_tag hold; in_ready low in RUN.
- Reconfig cost: DRAIN cycles = cycles to empty pipeline (<= 3 with out_ready high, unbounded with backpressure) + 1 APPLY cycle.
- Empty pipeline at cfg_valid: RUN -> DRAIN -> APPLY, cfg_ready on 2nd cycle after cfg_valid seen.
- Reset mid-DRAIN/APPLY: in-flight results and pending config discarded; defaults restored.

## Test plan
- Defaults: after reset, send addr aaaaaaaabbbbbbbb, tag 5A -> out_bucket 0, out_tag 5A, exactly 3 cycles later.
- cfg n=16, a=1, b=0, same addr -> bucket 1; then n=256 -> 0x11; then a=3, n=16 -> 3.
- Wrap: a=1, b=F0000000, n=16, same addr -> h = 01111111, bucket 0; n=20 -> lg 5, bucket 0x00; n=2^20 -> lg 16, cfg_err 1.
- Back-to-back 10 requests with out_ready toggled pseudo-randomly -> results in order, none lost/duplicated, outputs stable while stalled.
- cfg_valid asserted with 3 requests in flight -> those 3 use old config, in_ready 0 through DRAIN, cfg_ready single pulse, next request uses new config.
- rst_n pulsed low during DRAIN with out_ready low -> out_valid 0 immediately, config back to defaults, cfg_ready never pulses.
